// File: rtl/tdcomp_race_sequencer.sv
// Controls the time-domain comparator and runs TRIALS races per conversion (build option TDCOMP_ABORT_ON_TIMEOUT_EN stops at the first timeout).
// Latency: start -> first fire in 1+RST_CYC cycles; each trial takes RST_CYC plus up to TIMEOUT_CYC cycles.
// Backpressure: none; start is taken only in IDLE and dropped otherwise, ena=0 returns to IDLE.
module tdcomp_race_sequencer #(
    parameter int TRIALS      = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int RST_CYC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       comp_a,
    input  logic       comp_b,
    output logic       comp_rst,
    output logic       fire,
    output logic       busy,
    output logic       done,
    output logic       decision,
    output logic       tie,
    output logic       timeout,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
);
    localparam logic [7:0] TRIAL_LAST = 8'(TRIALS - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] RST_LAST   = 4'(RST_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_FIRE, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] a_sync, b_sync;
    logic                   a_s, b_s;
    logic [3:0]             rst_cnt;
    logic [7:0]             timer, trial_cnt;
    logic                   win_a, win_b, tmo_hit, resolved, start_acc;
    logic [7:0]             cnt_a_nxt, cnt_b_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], comp_a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], comp_b};
        end
    end

    assign a_s = a_sync[SYNC_STAGES-1];
    assign b_s = b_sync[SYNC_STAGES-1];

    always_comb begin
        win_a     = 1'b0;
        win_b     = 1'b0;
        tmo_hit   = 1'b0;
        resolved  = 1'b0;
        start_acc = ena && (state == S_IDLE) && start;
        if (state == S_FIRE) begin
            win_a    = a_s & ~b_s;
            win_b    = b_s & ~a_s;
            tmo_hit  = ~a_s & ~b_s & (timer == TMO_LAST);
            resolved = a_s | b_s | tmo_hit;
        end
        cnt_a_nxt = cnt_a + {7'd0, win_a};
        cnt_b_nxt = cnt_b + {7'd0, win_b};

        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RESET;
            S_RESET: if (rst_cnt == RST_LAST) state_nxt = S_FIRE;
            S_FIRE: begin
                if (resolved) begin
                    state_nxt = (trial_cnt == TRIAL_LAST) ? S_DONE : S_RESET;
`ifdef TDCOMP_ABORT_ON_TIMEOUT_EN
                    if (tmo_hit) state_nxt = S_DONE;
`endif
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (!ena) state_nxt = S_IDLE;
    end

    assign comp_rst = (state == S_RESET);
    assign fire     = (state == S_FIRE);
    assign busy     = (state == S_RESET) || (state == S_FIRE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rst_cnt   <= 4'd0;
            timer     <= 8'd0;
            trial_cnt <= 8'd0;
            cnt_a     <= 8'd0;
            cnt_b     <= 8'd0;
            timeout   <= 1'b0;
            decision  <= 1'b0;
            tie       <= 1'b0;
        end else begin
            state   <= state_nxt;
            // RESET and FIRE are always entered from another state, so both timers start at 0
            rst_cnt <= (state == S_RESET) ? rst_cnt + 4'd1 : 4'd0;
            timer   <= (state == S_FIRE) ? timer + 8'd1 : 8'd0;
            if (start_acc) begin
                trial_cnt <= 8'd0;
                cnt_a     <= 8'd0;
                cnt_b     <= 8'd0;
                timeout   <= 1'b0;
            end else if (ena) begin
                if (resolved) trial_cnt <= trial_cnt + 8'd1;
                cnt_a <= cnt_a_nxt;
                cnt_b <= cnt_b_nxt;
                if (tmo_hit) timeout <= 1'b1;
                // Final tallies land on the same edge, so decide from the next-state values
                if (state_nxt == S_DONE) begin
                    decision <= (cnt_a_nxt > cnt_b_nxt);
                    tie      <= (cnt_a_nxt == cnt_b_nxt);
                end
            end
        end
    end
endmodule

// File: tb/tb_tdcomp_race_sequencer.sv
// Bench for tdcomp_race_sequencer: comparator model plus queued expected results checked on every done pulse.
module tb_tdcomp_race_sequencer;
`ifdef TDCOMP_ABORT_ON_TIMEOUT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic       clk, rst_n, ena, start;
    logic       comp_a, comp_b;
    logic       comp_rst, fire, busy, done, decision, tie, timeout;
    logic [7:0] cnt_a, cnt_b;

    typedef struct {
        int ca;
        int cb;
        int dec;
        int tie;
        int tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Comparator model: per-trial arrival delays in cycles after fire, 0 = never arrives
    int   da[8], db[8];
    logic ma, mb, model_en, force_a, force_b, prev_fire;
    int   mtrial, fcyc;

    assign comp_a = model_en ? ma : force_a;
    assign comp_b = model_en ? mb : force_b;

    tdcomp_race_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .comp_a(comp_a), .comp_b(comp_b),
        .comp_rst(comp_rst), .fire(fire), .busy(busy), .done(done),
        .decision(decision), .tie(tie), .timeout(timeout),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        ma = 1'b0; mb = 1'b0; mtrial = -1; fcyc = 0; prev_fire = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!busy) mtrial = -1;
            if (comp_rst || !busy) begin
                ma = 1'b0; mb = 1'b0; fcyc = 0;
            end else if (fire) begin
                if (!prev_fire) mtrial++;
                fcyc++;
                if (mtrial >= 0 && mtrial < 8) begin
                    if (da[mtrial] != 0 && fcyc == da[mtrial]) ma = 1'b1;
                    if (db[mtrial] != 0 && fcyc == db[mtrial]) mb = 1'b1;
                end
            end
            prev_fire = fire;
        end
    end

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("cnt_a", int'(cnt_a), mon_e.ca);
                chk("cnt_b", int'(cnt_b), mon_e.cb);
                chk("decision", int'(decision), mon_e.dec);
                chk("tie", int'(tie), mon_e.tie);
                chk("timeout", int'(timeout), mon_e.tmo);
            end
        end
    end

    task automatic set_pat(input int a1, input int b1, input int a2, input int b2, input int split);
        for (int i = 0; i < 8; i++) begin
            da[i] = (i < split) ? a1 : a2;
            db[i] = (i < split) ? b1 : b2;
        end
    endtask

    task automatic run_conv(input exp_t e, output int fire_lat, output int done_lat);
        sb.push_back(e);
        fire_lat = 0;
        done_lat = 0;
        start = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (fire && fire_lat == 0) fire_lat = k;
            if (done) begin
                done_lat = k;
                break;
            end
        end
        if (done_lat == 0) chk("done_wait", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_fires(input int n);
        int   seen = 0;
        logic pf   = fire;
        for (int k = 0; k < 2000 && seen < n; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (fire && !pf) seen++;
            pf = fire;
        end
        if (seen < n) chk("fire_wait", seen, n);
    endtask

    int fl, dl, fire_seen;

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b1;
        model_en = 1'b0; force_a = 1'b1; force_b = 1'b1;
        set_pat(0, 0, 0, 0, 8);

        // Reset with inputs high and start asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({comp_rst, fire, busy, done, decision, tie, timeout, cnt_a, cnt_b}), 0);
        force_a = 1'b0; force_b = 1'b0; start = 1'b0;
        rst_n = 1'b1;
        fire_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (fire || busy) fire_seen = 1;
        end
        chk("idle_no_fire", fire_seen, 0);
        model_en = 1'b1;
        @(posedge clk); #1;

        // A always first
        set_pat(3, 6, 3, 6, 8);
        run_conv('{8, 0, 1, 0, 0}, fl, dl);
        chk("first_fire_latency", fl, 5);
        chk("result_hold_cnt_a", int'(cnt_a), 8);

        // A first on trials 1-4, B first on trials 5-8
        set_pat(3, 6, 6, 3, 4);
        run_conv('{4, 4, 0, 1, 0}, fl, dl);

        // Simultaneous arrivals
        set_pat(4, 4, 4, 4, 8);
        run_conv('{0, 0, 0, 1, 0}, fl, dl);

        // No arrivals at all
        set_pat(0, 0, 0, 0, 8);
        run_conv('{0, 0, 0, 1, 1}, fl, dl);
        chk("timeout_done_latency", dl, ABORT ? 69 : 545);

        // Only trial 3 times out
        set_pat(3, 6, 3, 6, 8);
        da[2] = 0; db[2] = 0;
        if (ABORT) run_conv('{2, 0, 1, 0, 1}, fl, dl);
        else       run_conv('{7, 0, 1, 0, 1}, fl, dl);

        // comp_a stuck high: each trial resolves on its first FIRE cycle
        model_en = 1'b0; force_a = 1'b1; force_b = 1'b0;
        run_conv('{8, 0, 1, 0, 0}, fl, dl);
        chk("stuck_done_latency", dl, 41);
        force_a = 1'b0; model_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Mid-FIRE of trial 3: ignored start, then ena drop
        set_pat(3, 6, 3, 6, 8);
        start = 1'b1;
        wait_fires(3);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("fire_after_ignored_start", int'(fire), 1);
        ena = 1'b0;
        @(posedge clk); #1;
        chk("ena_abort_fire", int'(fire), 0);
        chk("ena_abort_busy", int'(busy), 0);
        chk("ena_abort_comp_rst", int'(comp_rst), 0);
        chk("ena_abort_cnt_a_held", int'(cnt_a), 2);
        repeat (10) @(posedge clk);
        #1;
        ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Mid-FIRE of trial 3: asynchronous reset
        start = 1'b1;
        wait_fires(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_abort_fire", int'(fire), 0);
        chk("rst_abort_outputs", int'({comp_rst, busy, done, decision, tie, timeout, cnt_a, cnt_b}), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tdcomp_race_sequencer.md
Name: tdcomp_race_sequencer

Overview:
- Digital sequencer directly downstream of the time-domain comparator macro, and also its controller.
- Per trial: resets the comparator delay lines, launches a race, detects which comparator output (A or B) asserts first, and tallies the result.
- After TRIALS races, publishes a majority decision with tie/timeout flags.
- Drives the comparator's fire/reset pins and presents results to the uo_out mux.

Parameters:
- TRIALS, 8, races per conversion (1..255).
- TIMEOUT_CYC, 64, FIRE-state cycles without arrival before the trial is a timeout (2..255).
- RST_CYC, 4, cycles comp_rst is held per trial (1..15).
- SYNC_STAGES, 2, flop stages on each asynchronous comparator input (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  design enable; low forces IDLE
- start  in  1  conversion request, sampled in IDLE only
- comp_a  in  1  comparator output A; async, rises when A path arrives
- comp_b  in  1  comparator output B; async, rises when B path arrives
- comp_rst  out  1  resets comparator delay lines / arrival latches
- fire  out  1  launches the race; high throughout FIRE
- busy  out  1  conversion in progress (RESET or FIRE)
- done  out  1  one-cycle pulse; results valid
- decision  out  1  1 = A won strictly more trials than B
- tie  out  1  cnt_a == cnt_b at completion
- timeout  out  1  at least one trial timed out
- cnt_a  out  8  trials won by A
- cnt_b  out  8  trials won by B

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0; sync flops, tallies and timers cleared.
- comp_a/comp_b each pass through SYNC_STAGES flops; only synchronized a_s/b_s are used.
- States:
  - IDLE -> RESET on start=1 (registered transition, one edge).
  - RESET: comp_rst=1, busy=1, fire=0 for exactly RST_CYC cycles, then FIRE.
  - FIRE: fire=1, busy=1, timer increments each cycle. Resolved at the first edge where any of the following holds:
    - a_s & ~b_s: A win, cnt_a+1.
    - b_s & ~a_s: B win, cnt_b+1.
    - a_s & b_s: tie trial, no tally.
    - timer reaches TIMEOUT_CYC with neither input high: timeout trial, no tally, timeout flag set.
  - After resolution: trial counter+1. If trials < TRIALS -> RESET, else -> DONE.
  - DONE: one cycle; done=1, busy=0, fire=0. decision/tie computed from final tallies -> IDLE.
- First conversion start -> first fire rise latency: 1 + RST_CYC cycles.
- Results (decision, tie, timeout, cnt_a, cnt_b) are held from DONE until the next accepted start. At that start: cnt_a, cnt_b and timeout clear; decision and tie hold until the next DONE.
- start while busy or in DONE is ignored, with no queuing.
- An input already high at FIRE entry (stuck comparator) resolves on the first FIRE cycle per the rules above.
- ena=0 in any state: synchronous return to IDLE next edge; fire=comp_rst=busy=0; no done pulse; result outputs hold their last values.
- rst_n low mid-conversion: immediate abort, all outputs 0.
- Tallies are 8-bit and never wrap, since TRIALS <= 255.

Optional Feature:
- TDCOMP_ABORT_ON_TIMEOUT_EN defined: the first timeout trial ends the conversion immediately. FIRE -> DONE with timeout=1; tallies reflect trials completed so far.
- Undefined: a timeout trial is counted as a no-tally trial and the conversion continues to TRIALS.

Test Plan (TRIALS=8, TIMEOUT_CYC=64, RST_CYC=4, SYNC_STAGES=2):
- rst_n=0 with comp_a=comp_b=1 and start=1 -> all outputs 0. Release, hold start=0 -> remains IDLE, fire never rises.
- Pulse start; each trial comp_a rises 3 cycles after fire, comp_b 6 cycles after, both cleared by comp_rst -> first fire 5 cycles after start edge; done after 8 trials; cnt_a=8, cnt_b=0, decision=1, tie=0, timeout=0.
- A leads on trials 1-4, B leads on trials 5-8 -> cnt_a=4, cnt_b=4, tie=1, decision=0.
- comp_a and comp_b rise in the same cycle every trial -> cnt_a=cnt_b=0, tie=1, decision=0.
- Neither input ever rises:
  - Macro undefined: 8 timeouts, done after 1+8*(4+64)+... cycles; timeout=1, tie=1.
  - Macro defined: done right after the first 64-cycle FIRE, timeout=1.
- Mid-FIRE of trial 3: pulse start (ignored, trial count unaffected), then ena=0 -> next edge fire=0, busy=0, no done. Repeat with rst_n=0 mid-FIRE -> fire=0 immediately, all counts 0.
